// File: rtl/mem_port_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin memory-port arbiter.
package mem_port_rr_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    localparam logic [DATA_W-1:0] ERR_DATA = '0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } req_fields_t;

endpackage

// File: rtl/mem_port_rr_arbiter_if.sv
// Requester-side and memory-side bus of the arbiter.
interface mem_port_rr_arbiter_if #(
    parameter int NB_REQ     = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [NB_REQ-1:0]                 req_i;
    logic [NB_REQ-1:0][ADDR_WIDTH-1:0] addr_i;
    logic [NB_REQ-1:0]                 we_i;
    logic [NB_REQ-1:0][BE_WIDTH-1:0]   be_i;
    logic [NB_REQ-1:0][DATA_WIDTH-1:0] wdata_i;
    logic [NB_REQ-1:0]                 gnt_o;
    logic [NB_REQ-1:0]                 rvalid_o;
    logic [DATA_WIDTH-1:0]             rdata_o;
    logic                              rerr_o;

    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_we_o;
    logic [BE_WIDTH-1:0]   mem_be_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    // The arbiter masters the memory port.
    modport master (
        input  req_i, addr_i, we_i, be_i, wdata_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output gnt_o, rvalid_o, rdata_o, rerr_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
    );

    modport slave (
        output req_i, addr_i, we_i, be_i, wdata_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, rerr_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
    );

endinterface

// File: rtl/mem_port_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_pick #(
    parameter  int N  = 3,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          valid
);

    // Scan farthest-first so the nearest requester to ptr is the last to win.
    always_comb begin
        winner = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) winner = N'(1) << ((int'(ptr) + i) % N);
        end
    end

    assign valid = |req;

endmodule

// File: rtl/mem_port_rr_arbiter.sv
// Round-robin arbiter sharing one single-outstanding req/gnt/rvalid memory port.
module mem_port_rr_arbiter
    import mem_port_rr_arbiter_pkg::*;
#(
    parameter int NB_REQ     = 3,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int TIMEOUT    = 255
) (
    input logic clk,
    input logic rst_n,
    mem_port_rr_arbiter_if.master bus
);

    localparam int PW = $clog2(NB_REQ);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e      state_q, state_d;
    logic [PW-1:0] ptr_q, owner_q, win_idx, ptr_next;
    logic [CW-1:0] cnt_q;
    req_fields_t fld_q;
    logic [NB_REQ-1:0] win_oh;
    logic          win_vld;

    rr_pick #(.N(NB_REQ)) u_pick (
        .req    (bus.req_i),
        .ptr    (ptr_q),
        .winner (win_oh),
        .valid  (win_vld)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (win_oh[i]) win_idx = PW'(i);
        end
        ptr_next = (win_idx == PW'(NB_REQ - 1)) ? '0 : win_idx + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            fld_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && win_vld) begin
                owner_q <= win_idx;
                ptr_q   <= ptr_next;
                fld_q   <= '{addr:  bus.addr_i[win_idx],
                             we:    bus.we_i[win_idx],
                             be:    bus.be_i[win_idx],
                             wdata: bus.wdata_i[win_idx]};
            end
            // Held at 0 outside WAIT so it starts from 0 on every entry.
            cnt_q <= (state_q == WAIT) ? cnt_q + CW'(1) : '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.gnt_o    = '0;
        bus.rvalid_o = '0;
        bus.rdata_o  = '0;
        bus.rerr_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    bus.gnt_o = win_oh;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_gnt_i) begin
                    state_d = WAIT;
                    if (bus.mem_rvalid_i) begin
                        bus.rvalid_o[owner_q] = 1'b1;
                        bus.rdata_o           = bus.mem_rdata_i;
                        state_d               = IDLE;
                    end
                end
            end
            WAIT: begin
                if (bus.mem_rvalid_i) begin
                    bus.rvalid_o[owner_q] = 1'b1;
                    bus.rdata_o           = bus.mem_rdata_i;
                    state_d               = IDLE;
                end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT)) begin
                    bus.rvalid_o[owner_q] = 1'b1;
                    bus.rerr_o            = 1'b1;
                    bus.rdata_o           = ERR_DATA;
                    state_d               = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_req_o   = (state_q == ISSUE);
    assign bus.mem_addr_o  = fld_q.addr;
    assign bus.mem_we_o    = fld_q.we;
    assign bus.mem_be_o    = fld_q.be;
    assign bus.mem_wdata_o = fld_q.wdata;

endmodule
